// File: rtl/div_result_buf.sv
// Result buffer between the divider and its consumer: DEPTH-entry FIFO of {quotient, remainder}.
// Define DIV_RESULT_BUF_STATS_EN to add the saturating result_cnt pop counter.
module div_result_buf #(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      valid_in,
  output logic                      ready_out,
  input  logic [31:0]               quotient_in,
  input  logic [31:0]               remainder_in,
  input  logic                      flush,
  output logic                      valid_out,
  input  logic                      ready_in,
  output logic [31:0]               quotient,
  output logic [31:0]               remainder,
  output logic [$clog2(DEPTH):0]    count
`ifdef DIV_RESULT_BUF_STATS_EN
  ,
  output logic [15:0]               result_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   C_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] P_ONE = AW'(1);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   q_mem [DEPTH];
  logic [31:0]   r_mem [DEPTH];
  logic          push;
  logic          pop;

  // Handshakes decode from count only, so no input-to-output path.
  assign ready_out = (count != FULL);
  assign valid_out = (count != '0);

  assign push = valid_in & ready_out & ~flush;
  assign pop  = valid_out & ready_in & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + P_ONE;
      if (pop)  rd_ptr <= rd_ptr + P_ONE;
      case ({push, pop})
        2'b10:   count <= count + C_ONE;
        2'b01:   count <= count - C_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage is never cleared; valid_out qualifies the head.
  always_ff @(posedge clk) begin
    if (push) begin
      q_mem[wr_ptr] <= quotient_in;
      r_mem[wr_ptr] <= remainder_in;
    end
  end

  assign quotient  = q_mem[rd_ptr];
  assign remainder = r_mem[rd_ptr];

`ifdef DIV_RESULT_BUF_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_cnt <= '0;
    end else if (pop && result_cnt != 16'hFFFF) begin
      result_cnt <= result_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_div_result_buf.sv
// Scoreboard bench for div_result_buf: directed pushes queue their expected
// results; a negedge monitor pops and compares every delivered head entry.
module tb_div_result_buf;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] quotient_in;
  logic [31:0] remainder_in;
  logic        flush;
  logic        valid_out;
  logic        ready_in;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic [2:0]  count;
`ifdef DIV_RESULT_BUF_STATS_EN
  logic [15:0] result_cnt;
`endif

  int errors = 0;
  int checks = 0;
  logic [63:0] exq[$];

  always #5 clk = ~clk;

  div_result_buf #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_in     (valid_in),
    .ready_out    (ready_out),
    .quotient_in  (quotient_in),
    .remainder_in (remainder_in),
    .flush        (flush),
    .valid_out    (valid_out),
    .ready_in     (ready_in),
    .quotient     (quotient),
    .remainder    (remainder),
    .count        (count)
`ifdef DIV_RESULT_BUF_STATS_EN
    ,
    .result_cnt   (result_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] q, input logic [31:0] r,
                       input bit accepted);
    valid_in     = 1'b1;
    quotient_in  = q;
    remainder_in = r;
    if (accepted) exq.push_back({q, r});
  endtask

  // Monitor: a pop happens at the next edge when this holds.
  always @(negedge clk) begin
    if (rst_n && valid_out && ready_in && !flush) begin
      if (exq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got q=%0d expected no output at %0t",
                 quotient, $time);
      end else begin
        logic [63:0] e;
        e = exq.pop_front();
        chk("out_quotient", quotient, e[63:32]);
        chk("out_remainder", remainder, e[31:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    valid_in = 1'b0;
    quotient_in = '0;
    remainder_in = '0;
    flush = 1'b0;
    ready_in = 1'b0;
    #12;
    chk("rst_count", 32'(count), 0);
    chk("rst_valid_out", 32'(valid_out), 0);
    chk("rst_ready_out", 32'(ready_out), 1);
    tick();
    rst_n = 1'b1;

    // Single result q=4 r=1
    ready_in = 1'b1;
    offer(4, 1, 1'b1);
    tick();
    valid_in = 1'b0;
    chk("single_valid", 32'(valid_out), 1);
    chk("single_count", 32'(count), 1);
    tick();
    chk("single_drained", 32'(count), 0);
    chk("single_valid_low", 32'(valid_out), 0);

    // Fill with consumer stalled; fifth offer refused
    ready_in = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      offer(i, 100 + i, i <= 4);
      tick();
      if (i == 4) begin
        chk("fill_ready_low", 32'(ready_out), 0);
        chk("fill_count", 32'(count), 4);
      end
    end
    valid_in = 1'b0;
    chk("fill_hold_count", 32'(count), 4);
    chk("fill_hold_head", quotient, 1);
    ready_in = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("drain_count", 32'(count), 0);

    // Full with pop and push offered together: push refused
    ready_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      offer(10 + i, 0, 1'b1);
      tick();
    end
    offer(20, 7, 1'b0);
    ready_in = 1'b1;
    tick();
    chk("full_pop_count", 32'(count), 3);
    chk("full_pop_ready", 32'(ready_out), 1);
    ready_in = 1'b0;
    offer(20, 7, 1'b1);
    tick();
    valid_in = 1'b0;
    chk("full_repush_count", 32'(count), 4);
    ready_in = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("wrap_drain_count", 32'(count), 0);

    // Flush overrides push and pop
    ready_in = 1'b0;
    offer(30, 0, 1'b1);
    tick();
    offer(31, 0, 1'b1);
    tick();
    chk("pre_flush_count", 32'(count), 2);
    offer(32, 0, 1'b0);
    ready_in = 1'b1;
    flush = 1'b1;
    exq.delete();
    tick();
    flush = 1'b0;
    valid_in = 1'b0;
    chk("flush_count", 32'(count), 0);
    chk("flush_valid", 32'(valid_out), 0);
    offer(33, 3, 1'b1);
    tick();
    valid_in = 1'b0;
    tick();
    chk("post_flush_count", 32'(count), 0);

    // Asynchronous reset mid-stream
    ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      offer(40 + i, 0, 1'b1);
      tick();
    end
    valid_in = 1'b0;
    chk("pre_reset_count", 32'(count), 3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", 32'(count), 0);
    chk("async_rst_valid", 32'(valid_out), 0);
    chk("async_rst_ready", 32'(ready_out), 1);
    exq.delete();
    tick();
    rst_n = 1'b1;
    ready_in = 1'b1;
    offer(9, 2, 1'b1);
    tick();
    valid_in = 1'b0;
    tick();
    chk("post_reset_count", 32'(count), 0);

    // Stats: 6 pops, flush, 2 pops
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ready_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      offer(50 + i, i, 1'b1);
      tick();
    end
    valid_in = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      offer(60 + i, i, 1'b1);
      tick();
    end
    valid_in = 1'b0;
    tick();
    chk("stats_drain_count", 32'(count), 0);
`ifdef DIV_RESULT_BUF_STATS_EN
    chk("result_cnt", 32'(result_cnt), 8);
`endif

    tick();
    chk("scoreboard_empty", exq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
